car_cmd_uart_tx: RTL and testbench
==================================

// Module: car_cmd_uart_tx
// PURPOSE
//  Serialises the car's drive/barrier command bits into 8N1 UART frames on tx,
//  toward the SimulatedDevice link. A new frame goes out whenever the command
//  changes, and again every refresh period.
//  Frames are sent only while the engine is enabled. Sits between the
//  power/mode control logic and the tx pin.
// PARAMETERS
//  CLK_FREQ        100_000_000  sys_clk frequency, Hz
//  BAUD            9600         line rate; DIV = CLK_FREQ/BAUD, truncated (10416)
//  REFRESH_CYCLES  10_000_000   sys_clk cycles between periodic resends (100 ms)
// PORTS
//  sys_clk                 in   1  system clock, all logic on posedge
//  rst_n                   in   1  synchronous active-low reset
//  engine_on               in   1  1 = power on; gates all transmission
//  turn_left_signal        in   1  command bit 0
//  turn_right_signal       in   1  command bit 1
//  move_forward_signal     in   1  command bit 2
//  move_backward_signal    in   1  command bit 3
//  place_barrier_signal    in   1  command bit 4
//  destroy_barrier_signal  in   1  command bit 5
//  tx                      out  1  UART line, idles high
//  busy                    out  1  1 while a frame is on the line
//  frame_done              out  1  1-cycle pulse on the last stop-bit cycle
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): tx=1, busy=0, frame_done=0, state IDLE.
//   Baud counter, refresh timer, pending flag and last_sent (6'h00) are cleared.
//   Reset mid-frame aborts it; tx=1 from the next edge.
//  cmd = {2'b00, destroy, place, backward, forward, right, left}; inputs are
//   already synchronised and debounced upstream.
//  Send request (registered):
//   - engine_on=1 and cmd != last_sent sets pending.
//   - engine_on=1 and the refresh timer hits REFRESH_CYCLES-1 sets pending and
//     reloads the timer to 0. A change and a timer hit in the same cycle make
//     one request.
//   - engine_on 1->0 sets pending with a forced byte 8'h00, sent once.
//     After that nothing is sent while engine_on=0.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: if pending, latch shift_reg = current cmd (or 8'h00 on power-off),
//     last_sent = that byte, clear pending, go START. tx drops 1 cycle later.
//   - START: tx=0 for DIV cycles.
//   - DATA: 8 bits LSB first, DIV cycles each, with a 3-bit index.
//   - STOP: tx=1 for DIV cycles. frame_done pulses on the final cycle, then IDLE.
//   - A frame is exactly 10*DIV cycles. busy=1 in START, DATA and STOP.
//  A cmd change during a frame sets pending. Only one frame follows, carrying
//   the cmd value sampled at its IDLE latch, not a queue of intermediate values.
//  Back-to-back frames: the next START begins the cycle after STOP ends, with
//   no extra idle bit.
//  Baud counter runs 0..DIV-1 and restarts at every state entry. The refresh
//   timer is held at 0 while engine_on=0.
// STRUCTURE
//  Shared package (car_pkg): CMD_* bit indices, UART state encodings,
//   DEFAULT_BAUD, DEFAULT_CLK_FREQ.
//  One sub-module, uart_baud_tick: DIV counter with a restart input and a
//   1-cycle tick output. FSM, shifter and request logic stay in the top module.
// TESTING  (sim with CLK_FREQ=1000, BAUD=100 -> DIV=10, REFRESH_CYCLES=500)
//  1. rst_n=0 for 3 cycles, then engine_on=0 for 600 cycles.
//     -> tx=1 and busy=0 throughout, no frame_done.
//  2. engine_on=1, forward=1.
//     -> frame byte 8'h04: tx low 10 cycles, bits 0,0,1,0,0,0,0,0, stop high.
//     -> busy high for 100 cycles, frame_done exactly once.
//  3. Hold cmd 8'h04 constant.
//     -> identical frame resent every 500 cycles (±1). No frames in between.
//  4. Mid-frame: left=1, then right=1, then left=0.
//     -> exactly one follow-up frame with byte 8'h06, START immediately after STOP.
//  5. engine_on 1->0 while idle.
//     -> one frame 8'h00, then silence for 1000+ cycles despite cmd toggling.
//  6. rst_n=0 during DATA bit 4.
//     -> tx=1 and busy=0 next edge. After release with engine_on=1, a full fresh
//        frame of the current cmd.

Source files
------------

// File: rtl/car_pkg.sv
// Shared definitions for the car command UART link: command bit positions,
// transmitter state encoding and default timing parameters.
package car_pkg;

  localparam int CMD_LEFT     = 0;
  localparam int CMD_RIGHT    = 1;
  localparam int CMD_FORWARD  = 2;
  localparam int CMD_BACKWARD = 3;
  localparam int CMD_PLACE    = 4;
  localparam int CMD_DESTROY  = 5;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of each period.
// A restart forces the next cycle to be the first of a fresh period.
module uart_baud_tick #(
  parameter int DIV = 10416
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/car_cmd_uart_tx.sv
// Sends the 6-bit drive/barrier command as 8N1 UART frames whenever it changes,
// on a periodic refresh, and once as 8'h00 when the engine is switched off.
module car_cmd_uart_tx
  import car_pkg::*;
#(
  parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
  parameter int BAUD           = DEFAULT_BAUD,
  parameter int REFRESH_CYCLES = 10_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic engine_on,
  input  logic turn_left_signal,
  input  logic turn_right_signal,
  input  logic move_forward_signal,
  input  logic move_backward_signal,
  input  logic place_barrier_signal,
  input  logic destroy_barrier_signal,
  output logic tx,
  output logic busy,
  output logic frame_done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int TW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TW-1:0] REFRESH_LAST = TW'(REFRESH_CYCLES - 1);

  uart_state_t   state;
  uart_state_t   state_next;
  logic [7:0]    cmd;
  logic [7:0]    send_byte;
  logic [7:0]    shift_reg;
  logic [7:0]    last_sent;
  logic [2:0]    bit_idx;
  logic [TW-1:0] refresh_timer;
  logic          pending;
  logic          force_zero;
  logic          engine_prev;
  logic          refresh_hit;
  logic          power_off;
  logic          send_req;
  logic          latch;
  logic          baud_tick;
  logic          baud_restart;

  always_comb begin
    cmd               = '0;
    cmd[CMD_LEFT]     = turn_left_signal;
    cmd[CMD_RIGHT]    = turn_right_signal;
    cmd[CMD_FORWARD]  = move_forward_signal;
    cmd[CMD_BACKWARD] = move_backward_signal;
    cmd[CMD_PLACE]    = place_barrier_signal;
    cmd[CMD_DESTROY]  = destroy_barrier_signal;
  end

  assign refresh_hit  = engine_on && (refresh_timer == REFRESH_LAST);
  assign power_off    = engine_prev && !engine_on;
  assign send_req     = engine_on && ((cmd != last_sent) || refresh_hit);
  // A pending byte is taken either from idle or straight out of the stop bit,
  // so back-to-back frames need no idle gap.
  assign latch        = pending &&
                        ((state == UART_IDLE) || ((state == UART_STOP) && baud_tick));
  assign send_byte    = force_zero ? 8'h00 : cmd;
  assign baud_restart = (state_next != state);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .restart (baud_restart),
    .tick    (baud_tick)
  );

  // Power-off wins over a simultaneous latch so the 8'h00 frame is never lost.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      engine_prev   <= 1'b0;
      refresh_timer <= '0;
      pending       <= 1'b0;
      force_zero    <= 1'b0;
    end else begin
      engine_prev <= engine_on;
      if (!engine_on || refresh_hit) begin
        refresh_timer <= '0;
      end else begin
        refresh_timer <= refresh_timer + 1'b1;
      end
      if (power_off) begin
        pending    <= 1'b1;
        force_zero <= 1'b1;
      end else if (latch) begin
        pending    <= 1'b0;
        force_zero <= 1'b0;
      end else if (send_req) begin
        pending    <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= UART_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      UART_IDLE:  if (pending) state_next = UART_START;
      UART_START: if (baud_tick) state_next = UART_DATA;
      UART_DATA:  if (baud_tick && (bit_idx == 3'd7)) state_next = UART_STOP;
      UART_STOP:  if (baud_tick) state_next = pending ? UART_START : UART_IDLE;
      default:    state_next = UART_IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      UART_START: begin
        tx   = 1'b0;
        busy = 1'b1;
      end
      UART_DATA: begin
        tx   = shift_reg[0];
        busy = 1'b1;
      end
      UART_STOP: begin
        busy       = 1'b1;
        frame_done = baud_tick;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      last_sent <= '0;
      bit_idx   <= '0;
    end else if (latch) begin
      shift_reg <= send_byte;
      last_sent <= send_byte;
      bit_idx   <= '0;
    end else if ((state == UART_DATA) && baud_tick) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
      bit_idx   <= bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_car_cmd_uart_tx.sv
// Directed-plus-random bench for car_cmd_uart_tx: a line monitor decodes every
// frame from tx and the steps compare bytes and timing against expected values.
module tb_car_cmd_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int REFRESH  = 500;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic engine_on = 1'b0;
  logic turn_left_signal = 1'b0;
  logic turn_right_signal = 1'b0;
  logic move_forward_signal = 1'b0;
  logic move_backward_signal = 1'b0;
  logic place_barrier_signal = 1'b0;
  logic destroy_barrier_signal = 1'b0;
  logic tx;
  logic busy;
  logic frame_done;

  car_cmd_uart_tx #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .REFRESH_CYCLES (REFRESH)
  ) dut (
    .sys_clk                (sys_clk),
    .rst_n                  (rst_n),
    .engine_on              (engine_on),
    .turn_left_signal       (turn_left_signal),
    .turn_right_signal      (turn_right_signal),
    .move_forward_signal    (move_forward_signal),
    .move_backward_signal   (move_backward_signal),
    .place_barrier_signal   (place_barrier_signal),
    .destroy_barrier_signal (destroy_barrier_signal),
    .tx                     (tx),
    .busy                   (busy),
    .frame_done             (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         ok;
  } frame_t;

  frame_t frameQ[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pos = 0;
  int startCyc = 0;
  int idleViol = 0;
  bit inFrame = 1'b0;
  logic [FRAME-1:0] txS;
  logic [FRAME-1:0] busyS;
  logic [FRAME-1:0] doneS;

  always @(posedge sys_clk) cyc++;

  // Decodes a captured frame: every bit must hold for exactly DIV cycles,
  // busy must cover the whole frame and frame_done must hit only its last cycle.
  function automatic frame_t decodeFrame(input int s);
    frame_t f;
    logic [FRAME-1:0] doneExp;
    f.start = s;
    f.ok = 1'b1;
    f.data = '0;
    doneExp = '0;
    doneExp[FRAME-1] = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < DIV; j++) begin
        logic expBit;
        if (b == 0) expBit = 1'b0;
        else if (b == 9) expBit = 1'b1;
        else expBit = txS[b*DIV];
        if (txS[b*DIV+j] !== expBit) f.ok = 1'b0;
      end
    end
    for (int b = 0; b < 8; b++) f.data[b] = txS[(b+1)*DIV + DIV/2];
    if (busyS !== {FRAME{1'b1}}) f.ok = 1'b0;
    if (doneS !== doneExp) f.ok = 1'b0;
    return f;
  endfunction

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      inFrame = 1'b0;
    end else begin
      if (!inFrame) begin
        if (tx === 1'b0) begin
          inFrame = 1'b1;
          pos = 0;
          startCyc = cyc;
        end else if (busy !== 1'b0 || frame_done !== 1'b0) begin
          idleViol++;
        end
      end
      if (inFrame) begin
        txS[pos] = tx;
        busyS[pos] = busy;
        doneS[pos] = frame_done;
        pos++;
        if (pos == FRAME) begin
          frameQ.push_back(decodeFrame(startCyc));
          inFrame = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic eng, input logic [5:0] c);
    @(posedge sys_clk);
    #1;
    engine_on = eng;
    turn_left_signal = c[0];
    turn_right_signal = c[1];
    move_forward_signal = c[2];
    move_backward_signal = c[3];
    place_barrier_signal = c[4];
    destroy_barrier_signal = c[5];
  endtask

  function automatic frame_t getFrame(input int i);
    frame_t f;
    f.data = 8'hFF;
    f.start = -1;
    f.ok = 1'b0;
    if (i < frameQ.size()) f = frameQ[i];
    return f;
  endfunction

  task automatic waitFrames(input int n, input int budget, input string tag);
    int k = 0;
    while (frameQ.size() < n && k < budget) begin
      @(posedge sys_clk);
      k++;
    end
    #1;
    checkOutput({tag, "_timeout"}, 32'(frameQ.size() >= n), 32'd1);
  endtask

  task automatic waitInFrame(input int budget, input string tag);
    int k = 0;
    while (!inFrame && k < budget) begin
      @(posedge sys_clk);
      k++;
    end
    #1;
    checkOutput({tag, "_timeout"}, 32'(inFrame), 32'd1);
  endtask

  task automatic waitUntilCycle(input int target);
    while (cyc < target) @(posedge sys_clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input int idx, input logic [7:0] expData);
    frame_t f;
    f = getFrame(idx);
    checkOutput({tag, "_data"}, 32'(f.data), 32'(expData));
    checkOutput({tag, "_shape"}, 32'(f.ok), 32'd1);
  endtask

  initial begin
    int t0;
    int base;
    int gap;
    int k;
    frame_t fa;
    frame_t fb;
    logic [5:0] v1;
    logic [5:0] v2;
    logic [5:0] v3;
    logic [5:0] v6;

    // Step 1: reset, then engine off with random command activity.
    @(posedge sys_clk);
    #1;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) applyStimulus(1'b0, 6'($urandom));
    checkOutput("off_no_frames", 32'(frameQ.size()), 32'd0);
    checkOutput("off_idle_outputs", 32'(idleViol), 32'd0);

    // Step 2: power on with forward only.
    applyStimulus(1'b1, 6'h04);
    t0 = cyc;
    waitFrames(1, 300, "first");
    checkFrame("first", 0, 8'h04);
    checkOutput("first_latency", 32'(getFrame(0).start - t0), 32'd2);

    // Step 3: constant command is refreshed every REFRESH cycles.
    waitFrames(3, 1300, "refresh");
    checkFrame("refresh1", 1, 8'h04);
    checkFrame("refresh2", 2, 8'h04);
    gap = getFrame(1).start - getFrame(0).start;
    checkOutput("refresh_gap1", 32'(gap >= REFRESH - 1 && gap <= REFRESH + 1), 32'd1);
    gap = getFrame(2).start - getFrame(1).start;
    checkOutput("refresh_gap2", 32'(gap >= REFRESH - 1 && gap <= REFRESH + 1), 32'd1);

    // Step 4: directed changes during a refresh frame collapse into one frame.
    base = frameQ.size();
    waitInFrame(600, "mid_a");
    repeat ($urandom_range(3, 15)) @(posedge sys_clk);
    applyStimulus(1'b1, 6'h05);
    repeat ($urandom_range(3, 15)) @(posedge sys_clk);
    applyStimulus(1'b1, 6'h07);
    repeat ($urandom_range(3, 15)) @(posedge sys_clk);
    applyStimulus(1'b1, 6'h06);
    waitFrames(base + 2, 400, "follow_a");
    checkFrame("inflight_a", base, 8'h04);
    checkFrame("follow_a", base + 1, 8'h06);
    fa = getFrame(base);
    checkOutput("b2b_a", 32'(getFrame(base + 1).start - fa.start), 32'(FRAME));
    waitUntilCycle(fa.start + 400);
    checkOutput("single_follow_a", 32'(frameQ.size()), 32'(base + 2));

    // Step 4b: random command sequence during the next refresh frame.
    v1 = 6'($urandom_range(1, 63));
    v2 = 6'($urandom_range(1, 63));
    v3 = 6'($urandom_range(1, 63));
    k = 0;
    while (v3 == 6'h06 && k < 50) begin
      v3 = 6'($urandom_range(1, 63));
      k++;
    end
    if (v3 == 6'h06) v3 = 6'h21;
    base = frameQ.size();
    waitInFrame(600, "mid_b");
    repeat ($urandom_range(3, 15)) @(posedge sys_clk);
    applyStimulus(1'b1, v1);
    repeat ($urandom_range(3, 15)) @(posedge sys_clk);
    applyStimulus(1'b1, v2);
    repeat ($urandom_range(3, 15)) @(posedge sys_clk);
    applyStimulus(1'b1, v3);
    waitFrames(base + 2, 400, "follow_b");
    checkFrame("inflight_b", base, 8'h06);
    checkFrame("follow_b", base + 1, {2'b00, v3});
    fb = getFrame(base);
    checkOutput("b2b_b", 32'(getFrame(base + 1).start - fb.start), 32'(FRAME));
    waitUntilCycle(fb.start + 400);
    checkOutput("single_follow_b", 32'(frameQ.size()), 32'(base + 2));

    // Step 5: power off while idle sends one zero frame, then silence.
    base = frameQ.size();
    applyStimulus(1'b0, v3);
    t0 = cyc;
    waitFrames(base + 1, 300, "poweroff");
    checkFrame("poweroff", base, 8'h00);
    checkOutput("poweroff_latency", 32'(getFrame(base).start - t0), 32'd2);
    for (int i = 0; i < 1100; i++) applyStimulus(1'b0, 6'($urandom));
    checkOutput("poweroff_silence", 32'(frameQ.size()), 32'(base + 1));

    // Step 6: reset in the middle of data bit 4, then a fresh frame.
    v6 = 6'($urandom_range(1, 63));
    base = frameQ.size();
    applyStimulus(1'b1, v6);
    waitInFrame(50, "abort");
    k = 0;
    while (pos < 52 && k < 100) begin
      @(posedge sys_clk);
      k++;
    end
    #1;
    rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    checkOutput("abort_tx", 32'(tx), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;
    waitFrames(base + 1, 300, "fresh");
    checkFrame("fresh", base, {2'b00, v6});
    checkOutput("fresh_latency", 32'(getFrame(base).start - t0), 32'd2);
    checkOutput("idle_outputs_total", 32'(idleViol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
